// File: rtl/ace_snoop_read_responder_pkg.sv
// ace_resp_pkg: snoop/response encodings and FSM state type for the ACE snoop read responder.
package ace_resp_pkg;
  localparam logic [3:0] SNP_READ_ONCE      = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED    = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN     = 4'b0010;
  localparam logic [3:0] SNP_READ_NSD       = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE    = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED   = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID  = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID   = 4'b1101;
  localparam int CR_DATA_TRANSFER = 0;
  localparam int CR_PASS_DIRTY    = 2;
  localparam int CR_IS_SHARED     = 3;
  localparam logic [1:0] RRESP_OKAY = 2'b00;
  typedef enum logic [2:0] {IDLE, WAIT_CR, COLLECT, MEM_RD, WRITEBACK, RESP} state_t;
  function automatic logic is_read(input logic [3:0] s);
    return s inside {SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD, SNP_READ_UNIQUE};
  endfunction
  function automatic logic reports_shared(input logic [3:0] s);
    return s inside {SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD};
  endfunction
endpackage

// File: rtl/ace_snoop_read_responder_if.sv
// ace_snoop_read_responder_if: request, snoop response/data, memory and R channel bundle.
interface ace_snoop_read_responder_if #(
  parameter int ID_SIZE        = 8,
  parameter int ADDR_SIZE      = 32,
  parameter int DATA_SIZE      = 128,
  parameter int BEATS_PER_LINE = 4
);
  localparam int LINE = DATA_SIZE * BEATS_PER_LINE;
  logic                 req_valid;
  logic                 req_ready;
  logic [ID_SIZE-1:0]   req_id;
  logic [3:0]           req_snoop;
  logic [ADDR_SIZE-1:0] req_addr;
  logic                 cr_valid;
  logic                 cr_ready;
  logic [3:0]           cr_resp;
  logic                 cd_valid;
  logic                 cd_ready;
  logic [DATA_SIZE-1:0] cd_data;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [LINE-1:0]      mem_wrdata;
  logic [LINE-1:0]      mem_rddata;
  logic                 RVALID;
  logic                 RREADY;
  logic [ID_SIZE-1:0]   RID;
  logic [DATA_SIZE-1:0] RDATA;
  logic                 RLAST;
  logic [3:0]           RRESP;
  modport slave (
    input  req_valid, req_id, req_snoop, req_addr, cr_valid, cr_resp, cd_valid, cd_data,
           mem_rddata, RREADY,
    output req_ready, cr_ready, cd_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wrdata,
           RVALID, RID, RDATA, RLAST, RRESP
  );
  modport master (
    output req_valid, req_id, req_snoop, req_addr, cr_valid, cr_resp, cd_valid, cd_data,
           mem_rddata, RREADY,
    input  req_ready, cr_ready, cd_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wrdata,
           RVALID, RID, RDATA, RLAST, RRESP
  );
endinterface

// File: rtl/ace_snoop_read_responder_line_buffer.sv
// ace_line_buffer: one cache line of beats with per-beat write, full-line load and indexed read.
module ace_line_buffer #(
  parameter int DATA_SIZE      = 128,
  parameter int BEATS_PER_LINE = 4,
  parameter int IW             = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_wr_en,
  input  logic [IW-1:0]                       i_wr_idx,
  input  logic [DATA_SIZE-1:0]                i_wr_data,
  input  logic                                i_load_en,
  input  logic [DATA_SIZE*BEATS_PER_LINE-1:0] i_load_line,
  input  logic [IW-1:0]                       i_rd_idx,
  output logic [DATA_SIZE-1:0]                o_rd_data,
  output logic [DATA_SIZE*BEATS_PER_LINE-1:0] o_line
);
  logic [BEATS_PER_LINE-1:0][DATA_SIZE-1:0] r_beats;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_beats <= '0;
    else if (i_load_en) r_beats <= i_load_line;
    else if (i_wr_en) r_beats[i_wr_idx] <= i_wr_data;
  assign o_line    = r_beats;
  assign o_rd_data = r_beats[i_rd_idx];
endmodule

// File: rtl/ace_snoop_read_responder.sv
// ace_snoop_read_responder: sources a line from snoop data or memory, writes dirty data back, streams it on R.
// Optional ACE_CRITICAL_WORD_FIRST_EN starts the R burst at the addressed beat and wraps.
module ace_snoop_read_responder
  import ace_resp_pkg::*;
#(
  parameter int ID_SIZE        = 8,
  parameter int ADDR_SIZE      = 32,
  parameter int DATA_SIZE      = 128,
  parameter int BEATS_PER_LINE = 4,
  parameter int MEM_RD_LAT     = 2
) (
  input logic ACLK,
  input logic ARESET,
  ace_snoop_read_responder_if.slave bus
);
  localparam int LINE = DATA_SIZE * BEATS_PER_LINE;
  localparam int CW   = BEATS_PER_LINE > 1 ? $clog2(BEATS_PER_LINE) : 1;
  localparam int BOFF = $clog2(DATA_SIZE / 8);
  localparam int LW   = $clog2(MEM_RD_LAT + 1);
  localparam logic [CW-1:0] LAST_K = CW'(BEATS_PER_LINE - 1);
  localparam logic [ADDR_SIZE-1:0] LINE_MASK = ADDR_SIZE'(LINE / 8 - 1);
  state_t               r_state;
  logic                 r_req_ready, r_cr_ready, r_cd_ready, r_mem_rd_en, r_mem_wr_en, r_rvalid;
  logic                 r_dataless, r_shared, r_pass_dirty;
  logic [ID_SIZE-1:0]   r_id;
  logic [3:0]           r_snoop;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [CW-1:0]        r_k;
  logic [LW-1:0]        r_lat;
  logic [CW-1:0]        w_start, w_end, w_next;
  logic                 w_last, w_cd_hs, w_load;
  logic [DATA_SIZE-1:0] w_beat;
  logic [LINE-1:0]      w_line;
`ifdef ACE_CRITICAL_WORD_FIRST_EN
  assign w_start = CW'(r_addr >> BOFF) & LAST_K;
`else
  assign w_start = '0;
`endif
  assign w_end   = (w_start + LAST_K) & LAST_K;
  assign w_next  = (r_k == LAST_K) ? '0 : r_k + 1'b1;
  assign w_last  = r_dataless || r_k == w_end;
  assign w_cd_hs = r_cd_ready && bus.cd_valid;
  assign w_load  = r_state == MEM_RD && r_lat == LW'(MEM_RD_LAT);
  ace_line_buffer #(.DATA_SIZE(DATA_SIZE), .BEATS_PER_LINE(BEATS_PER_LINE), .IW(CW)) u_buf (
    .clk(ACLK), .rst(ARESET),
    .i_wr_en(w_cd_hs), .i_wr_idx(r_k), .i_wr_data(bus.cd_data),
    .i_load_en(w_load), .i_load_line(bus.mem_rddata),
    .i_rd_idx(r_k), .o_rd_data(w_beat), .o_line(w_line)
  );
  assign bus.req_ready  = r_req_ready;
  assign bus.cr_ready   = r_cr_ready;
  assign bus.cd_ready   = r_cd_ready;
  assign bus.mem_rd_en  = r_mem_rd_en;
  assign bus.mem_wr_en  = r_mem_wr_en;
  assign bus.mem_addr   = r_addr & ~LINE_MASK;
  assign bus.mem_wrdata = r_mem_wr_en ? w_line : '0;
  assign bus.RVALID     = r_rvalid;
  assign bus.RID        = r_id;
  assign bus.RDATA      = r_dataless ? '0 : w_beat;
  assign bus.RLAST      = r_rvalid && w_last;
  assign bus.RRESP      = r_rvalid ? {r_shared, 1'b0, RRESP_OKAY} : 4'b0000;
  // Every handshake output is a flop loaded on the transition into the state that owns it.
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_cr_ready   <= 1'b0;
      r_cd_ready   <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      r_mem_wr_en  <= 1'b0;
      r_rvalid     <= 1'b0;
      r_dataless   <= 1'b0;
      r_shared     <= 1'b0;
      r_pass_dirty <= 1'b0;
      r_id         <= '0;
      r_snoop      <= '0;
      r_addr       <= '0;
      r_k          <= '0;
      r_lat        <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (bus.req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_cr_ready  <= 1'b1;
            r_id        <= bus.req_id;
            r_snoop     <= bus.req_snoop;
            r_addr      <= bus.req_addr;
            r_dataless  <= 1'b0;
            r_state     <= WAIT_CR;
          end else r_req_ready <= 1'b1;
        WAIT_CR:
          if (bus.cr_valid && r_cr_ready) begin
            r_cr_ready   <= 1'b0;
            r_shared     <= bus.cr_resp[CR_IS_SHARED] && reports_shared(r_snoop);
            r_pass_dirty <= bus.cr_resp[CR_PASS_DIRTY];
            r_k          <= '0;
            if (bus.cr_resp[CR_DATA_TRANSFER]) begin
              r_cd_ready <= 1'b1;
              r_state    <= COLLECT;
            end else if (is_read(r_snoop)) begin
              r_mem_rd_en <= 1'b1;
              r_lat       <= '0;
              r_state     <= MEM_RD;
            end else begin
              r_dataless <= 1'b1;
              r_rvalid   <= 1'b1;
              r_state    <= RESP;
            end
          end
        COLLECT:
          if (w_cd_hs) begin
            r_k <= w_next;
            if (r_k == LAST_K) begin
              r_cd_ready <= 1'b0;
              if (r_pass_dirty && r_snoop != SNP_MAKE_INVALID) begin
                r_mem_wr_en <= 1'b1;
                r_state     <= WRITEBACK;
              end else begin
                r_rvalid <= 1'b1;
                r_k      <= w_start;
                r_state  <= RESP;
              end
            end
          end
        MEM_RD: begin
          r_mem_rd_en <= 1'b0;
          r_lat       <= r_lat + 1'b1;
          if (w_load) begin
            r_rvalid <= 1'b1;
            r_k      <= w_start;
            r_state  <= RESP;
          end
        end
        WRITEBACK: begin
          r_mem_wr_en <= 1'b0;
          r_rvalid    <= 1'b1;
          r_k         <= w_start;
          r_state     <= RESP;
        end
        RESP:
          if (r_rvalid && bus.RREADY) begin
            if (w_last) begin
              r_rvalid    <= 1'b0;
              r_req_ready <= 1'b1;
              r_state     <= IDLE;
            end else r_k <= w_next;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: doc/ace_snoop_read_responder.md
Name: ace_snoop_read_responder

Overview:
Parametrised successor to the initiating-master response engine in the ACE interconnect. Accepts one snoop-backed read per transaction, then sources the cache line from one of two places: snoop data beats (CD channel) when the snooped cache supplies data, or memory after a fixed-latency read when it does not. Writes dirty lines back to memory, then streams the line to the winning master on the AXI R channel with full RVALID/RREADY back-pressure. Sits between the snoop aggregator and the memory port, per initiating master.

Parameters:
ID_SIZE, 8, RID/req_id width
ADDR_SIZE, 32, address width
DATA_SIZE, 128, beat width (power of 2, ≥32)
BEATS_PER_LINE, 4, beats per cache line (power of 2, ≥1); LINE = DATA_SIZE*BEATS_PER_LINE
MEM_RD_LAT, 2, cycles from mem_rd_en to valid mem_rddata (≥1)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous, active-high reset
req_valid  in  1  new transaction
req_ready  out  1  high only in IDLE
req_id  in  ID_SIZE  transaction ID
req_snoop  in  4  ACSNOOP encoding
req_addr  in  ADDR_SIZE  request address
cr_valid  in  1  snoop response valid
cr_ready  out  1  high only in WAIT_CR
cr_resp  in  4  CRRESP: [0] DataTransfer, [2] PassDirty, [3] IsShared
cd_valid  in  1  snoop data beat valid
cd_ready  out  1  high only in COLLECT
cd_data  in  DATA_SIZE  snoop data beat
mem_rd_en  out  1  one-cycle read strobe
mem_wr_en  out  1  one-cycle write strobe
mem_addr  out  ADDR_SIZE  line-aligned address
mem_wrdata  out  LINE  writeback line
mem_rddata  in  LINE  read line
RVALID  out  1  R beat valid
RREADY  in  1  master accepts beat
RID  out  ID_SIZE  = captured req_id
RDATA  out  DATA_SIZE  beat data
RLAST  out  1  final beat
RRESP  out  4  [1:0] OKAY=00, [2] PassDirty=0, [3] IsShared

Behaviour:
- Reset (asynchronous, any state, including mid-burst): FSM→IDLE; all outputs 0; line buffer and counters cleared. req_ready rises in the first cycle after ARESET deasserts.
- IDLE: req_valid&req_ready captures id/snoop/addr → WAIT_CR. req_valid is ignored in every other state.
- WAIT_CR: on cr_valid, capture cr_resp.
  - DataTransfer=1 → COLLECT.
  - DataTransfer=0 and snoop is a read type (ReadOnce/Shared/Clean/NotSharedDirty/Unique) → MEM_RD.
  - Otherwise (CleanShared/CleanInvalid/MakeInvalid) → RESP, dataless.
- COLLECT: each cd_valid&cd_ready writes one beat at beat counter k, then k increments. After beat BEATS_PER_LINE-1, k wraps to 0.
  - PassDirty=1 and snoop ≠ MakeInvalid → WRITEBACK.
  - Otherwise → RESP.
  - A cd_valid arriving in the same cycle as cr_valid is not accepted; the source holds it.
- WRITEBACK: exactly one cycle with mem_wr_en=1, mem_addr = req_addr with low log2(LINE/8) bits cleared, mem_wrdata = buffer → RESP.
- MEM_RD: mem_rd_en=1 for the first cycle only. mem_rddata is sampled into the buffer MEM_RD_LAT cycles later → RESP. RVALID asserts the following cycle.
- RESP data response: BEATS_PER_LINE beats.
  - RVALID held high, and RDATA/RLAST/RRESP held stable, while RREADY=0.
  - Beat advances on RVALID&RREADY. RLAST=1 only on the final beat.
  - After the final handshake → IDLE; req_ready=1 in the next cycle. There is no back-to-back overlap.
- RESP dataless response: one beat, RDATA=0, RLAST=1.
- RRESP[3] = captured IsShared for ReadShared/ReadClean/ReadNotSharedDirty; 0 otherwise. RRESP[2:0] always 0.
- Counters are log2(BEATS_PER_LINE) wide, minimum 1 bit. With BEATS_PER_LINE=1, every beat is last.

Optional Feature:
ACE_CRITICAL_WORD_FIRST_EN
- Defined: R streaming starts at beat index s = req_addr[log2(LINE/8)-1 : log2(DATA_SIZE/8)] and proceeds s, s+1, … modulo BEATS_PER_LINE. RLAST marks the beat at (s-1) mod BEATS_PER_LINE. Buffer fill order and writeback are unchanged.
- Undefined: beats always stream 0…BEATS_PER_LINE-1.

Decomposition:
- Package ace_resp_pkg:
  - ACSNOOP localparams (ReadOnce 0000, ReadShared 0001, ReadClean 0010, ReadNotSharedDirty 0011, ReadUnique 0111, CleanShared 1000, CleanInvalid 1001, MakeInvalid 1101)
  - CRRESP bit indices
  - RRESP OKAY encoding
  - FSM state enum (IDLE, WAIT_CR, COLLECT, MEM_RD, WRITEBACK, RESP)
- Sub-module ace_line_buffer: BEATS_PER_LINE×DATA_SIZE storage with beat-write port, full-line load/read, and indexed beat read.

Test Plan:
- ReadShared, cr_resp=1001, 4 beats A0..A3 on CD → no memory access; R beats A0..A3, RLAST on beat 3, RRESP=1000, RID=req_id.
- ReadUnique, cr_resp=0000, mem_rddata=L → mem_rd_en one cycle, mem_addr=addr&~0x3F; RVALID asserts MEM_RD_LAT+1 cycles after mem_rd_en; R beats = L[127:0]..L[511:384], RRESP=0000.
- ReadClean, cr_resp=0101 with CD data → one-cycle mem_wr_en with mem_wrdata = collected line before the first RVALID; R data = same line.
- MakeInvalid, cr_resp=0000 → single R beat, RDATA=0, RLAST=1; no mem strobes.
- RREADY held low 5 cycles on beat 2 → RVALID/RDATA/RLAST stable throughout; no beat lost or duplicated. Then assert ARESET mid-burst → all outputs 0 immediately; req_ready=1 after release.
- ACE_CRITICAL_WORD_FIRST_EN defined, req_addr=0x1020 → R order beats 2,3,0,1; RLAST on beat 1.
